// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port between two clients.
// One request pulse per grant, ready/data returned to owner, watchdog abort.
module sram_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit RR_INIT        = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_wren,
  input  logic [17:0] a_address,
  input  logic [15:0] a_to_mem,
  output logic [15:0] a_from_mem,
  output logic        a_ready,
  output logic        a_err,
  input  logic        b_req,
  input  logic        b_wren,
  input  logic [17:0] b_address,
  input  logic [15:0] b_to_mem,
  output logic [15:0] b_from_mem,
  output logic        b_ready,
  output logic        b_err,
  output logic [17:0] mem_address,
  output logic [15:0] mem_to_mem,
  output logic        mem_wren,
  output logic        mem_req,
  input  logic [15:0] mem_from_mem,
  input  logic        mem_ready,
  output logic        grant_b
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [17:0] addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d;
  logic        wren_q, wren_d;
  logic        mreq_q, mreq_d;
  logic        gnt_q, gnt_d;
  logic [15:0] a_dat_q, a_dat_d;
  logic [15:0] b_dat_q, b_dat_d;
  logic        a_rdy_q, a_rdy_d;
  logic        b_rdy_q, b_rdy_d;
  logic        a_err_q, a_err_d;
  logic        b_err_q, b_err_d;
  logic        win_b;
  logic [15:0] res;
  logic        fin;
  logic        tout;

  // On a tie the client that did not win last time gets the port
  assign win_b = b_req & (~a_req | ~last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wren_d  = wren_q;
    mreq_d  = 1'b0;
    gnt_d   = gnt_q;
    a_dat_d = a_dat_q;
    b_dat_d = b_dat_q;
    a_rdy_d = 1'b0;
    b_rdy_d = 1'b0;
    a_err_d = 1'b0;
    b_err_d = 1'b0;
    res     = 16'h0000;
    fin     = 1'b0;
    tout    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (a_req | b_req) begin
          gnt_d   = win_b;
          addr_d  = win_b ? b_address : a_address;
          wdat_d  = win_b ? b_to_mem : a_to_mem;
          wren_d  = win_b ? b_wren : a_wren;
          mreq_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_ready) begin
          fin = 1'b1;
          res = mem_from_mem;
        end else if (cnt_q == TMAX) begin
          fin  = 1'b1;
          tout = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (fin) begin
          state_d = DONE;
          if (gnt_q) begin
            b_dat_d = res;
            b_err_d = tout;
            b_rdy_d = 1'b1;
          end else begin
            a_dat_d = res;
            a_err_d = tout;
            a_rdy_d = 1'b1;
          end
        end
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= RR_INIT;
      cnt_q   <= 8'd0;
      addr_q  <= 18'd0;
      wdat_q  <= 16'd0;
      wren_q  <= 1'b0;
      mreq_q  <= 1'b0;
      gnt_q   <= 1'b0;
      a_dat_q <= 16'd0;
      b_dat_q <= 16'd0;
      a_rdy_q <= 1'b0;
      b_rdy_q <= 1'b0;
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wren_q  <= wren_d;
      mreq_q  <= mreq_d;
      gnt_q   <= gnt_d;
      a_dat_q <= a_dat_d;
      b_dat_q <= b_dat_d;
      a_rdy_q <= a_rdy_d;
      b_rdy_q <= b_rdy_d;
      a_err_q <= a_err_d;
      b_err_q <= b_err_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_to_mem  = wdat_q;
  assign mem_wren    = wren_q;
  assign mem_req     = mreq_q;
  assign grant_b     = gnt_q;
  assign a_from_mem  = a_dat_q;
  assign a_ready     = a_rdy_q;
  assign a_err       = a_err_q;
  assign b_from_mem  = b_dat_q;
  assign b_ready     = b_rdy_q;
  assign b_err       = b_err_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM controller model plus a
// transaction-level reference of grants, latency and returned data.
module tb_sram_port_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        a_req = 0, a_wren = 0;
  logic [17:0] a_address = 0;
  logic [15:0] a_to_mem = 0;
  logic [15:0] a_from_mem;
  logic        a_ready, a_err;
  logic        b_req = 0, b_wren = 0;
  logic [17:0] b_address = 0;
  logic [15:0] b_to_mem = 0;
  logic [15:0] b_from_mem;
  logic        b_ready, b_err;
  logic [17:0] mem_address;
  logic [15:0] mem_to_mem;
  logic        mem_wren, mem_req, grant_b;
  logic [15:0] mem_from_mem = 0;
  logic        mem_ready = 0;

  sram_port_arbiter #(.TIMEOUT_CYCLES(TO), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wren(a_wren), .a_address(a_address),
    .a_to_mem(a_to_mem), .a_from_mem(a_from_mem),
    .a_ready(a_ready), .a_err(a_err),
    .b_req(b_req), .b_wren(b_wren), .b_address(b_address),
    .b_to_mem(b_to_mem), .b_from_mem(b_from_mem),
    .b_ready(b_ready), .b_err(b_err),
    .mem_address(mem_address), .mem_to_mem(mem_to_mem),
    .mem_wren(mem_wren), .mem_req(mem_req),
    .mem_from_mem(mem_from_mem), .mem_ready(mem_ready),
    .grant_b(grant_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic tb_check(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  logic [15:0] sram [int];
  logic [15:0] ref_mem [int];
  int   ctl_lat = 1;
  bit   pv = 0, pb, pw;
  logic [17:0] pa;
  logic [15:0] pd;
  int   pl, pc;
  bit   lw = 0, mprev = 0, ea, eb, wb, perr;
  bit   [1:0] rseen = 0;
  int   rises = 0;
  int   inj = 0;
  logic [15:0] expf [2];
  logic [15:0] d;
  bit   grant_log [$];

  // Controller model and transaction scoreboard, evaluated mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      pv = 0; lw = 0; mprev = 0; rseen = 0; inj = 0;
      mem_ready = 0; mem_from_mem = 0;
      expf[0] = 0; expf[1] = 0;
    end else begin
      mem_ready = 0;
      ea = 0; eb = 0;
      if (pv) begin
        pc++;
        if (pl != 0 && pc == pl + 1) begin
          tb_check("bus_addr", 32'(mem_address), 32'(pa));
          tb_check("bus_wren", 32'(mem_wren), 32'(pw));
          mem_ready = 1;
          if (pw) begin
            sram[int'(pa)] = pd;
            mem_from_mem = ~pd;
          end else begin
            mem_from_mem = sram.exists(int'(pa)) ? sram[int'(pa)] : 16'h0;
          end
        end
        if (pc == ((pl == 0) ? 1 + TO : 2 + pl)) begin
          ea = !pb;
          eb = pb;
        end
      end
      if (inj > 0) begin
        inj--;
        if (inj == 0) begin
          mem_ready = 1;
          mem_from_mem = 16'hDEAD;
        end
      end
      if (a_ready || ea) tb_check("a_ready", 32'(a_ready), 32'(ea));
      if (b_ready || eb) tb_check("b_ready", 32'(b_ready), 32'(eb));
      if (ea || eb) begin
        perr = (pl == 0);
        if (perr) d = 16'h0;
        else if (pw) d = ~pd;
        else d = ref_mem.exists(int'(pa)) ? ref_mem[int'(pa)] : 16'h0;
        if (!perr && pw) ref_mem[int'(pa)] = pd;
        expf[pb] = d;
        tb_check("err", 32'(pb ? b_err : a_err), 32'(perr));
        tb_check("a_from", 32'(a_from_mem), 32'(expf[0]));
        tb_check("b_from", 32'(b_from_mem), 32'(expf[1]));
        lw = pb;
        pv = 0;
        if (perr) inj = 2;
      end
      if (mem_req && mprev) tb_check("mreq_pulse", 32'(mem_req), 0);
      if (mem_req && !mprev) begin
        rises++;
        tb_check("overlap", 32'(pv), 0);
        tb_check("grant_req", 32'(rseen == 2'b00), 0);
        wb = (rseen == 2'b11) ? !lw : rseen[0];
        tb_check("grant_b", 32'(grant_b), 32'(wb));
        tb_check("g_addr", 32'(mem_address), 32'(wb ? b_address : a_address));
        tb_check("g_data", 32'(mem_to_mem), 32'(wb ? b_to_mem : a_to_mem));
        tb_check("g_wren", 32'(mem_wren), 32'(wb ? b_wren : a_wren));
        pv = 1; pb = wb; pc = 0;
        pw = wb ? b_wren : a_wren;
        pa = wb ? b_address : a_address;
        pd = wb ? b_to_mem : a_to_mem;
        pl = (ctl_lat >= 0) ? ctl_lat : int'($urandom_range(0, 7));
        grant_log.push_back(wb);
      end
      mprev = mem_req;
      rseen = {a_req, b_req};
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic xfer(input bit b, input bit w, input logic [17:0] ad,
                      input logic [15:0] dd, input int hold);
    int k;
    if (b) begin
      b_wren = w; b_address = ad; b_to_mem = dd; b_req = 1;
    end else begin
      a_wren = w; a_address = ad; a_to_mem = dd; a_req = 1;
    end
    k = 0;
    do begin
      tick();
      k++;
    end while (!(b ? b_ready : a_ready) && k < 60);
    tb_check(b ? "b_done" : "a_done", 32'(b ? b_ready : a_ready), 1);
    repeat (hold) tick();
    if (b) b_req = 0;
    else a_req = 0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (pv && k < 100) begin
      tick();
      k++;
    end
    tb_check("idle_to", 32'(pv), 0);
    repeat (2) tick();
  endtask

  task automatic client(input bit b, input int n);
    logic [17:0] ad;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(1, 6)) tick();
      ad = 18'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) ad = ad | 18'h3FFF8;
      xfer(b, 1'($urandom_range(0, 1)), ad, 16'($urandom), 0);
    end
  endtask

  task automatic chk_zero();
    tb_check("z_mem", {13'b0, mem_req, mem_wren, mem_address}, 0);
    tb_check("z_wdat", 32'(mem_to_mem), 0);
    tb_check("z_a", {14'b0, a_ready, a_err, a_from_mem}, 0);
    tb_check("z_b", {14'b0, b_ready, b_err, b_from_mem}, 0);
    tb_check("z_gnt", 32'(grant_b), 0);
  endtask

  int r0, k;

  initial begin
    repeat (3) tick();
    chk_zero();
    rst = 0;
    tick();

    sram[32'h12] = 16'hBEEF;
    ref_mem[32'h12] = 16'hBEEF;
    r0 = rises;
    xfer(0, 0, 18'h00012, 16'h0, 0);
    wait_idle();
    tb_check("rd_beef", 32'(a_from_mem), 32'h0000BEEF);
    tb_check("rd_rises", 32'(rises - r0), 1);

    xfer(1, 1, 18'h3FFFF, 16'h1234, 0);
    xfer(0, 0, 18'h3FFFF, 16'h0, 0);
    wait_idle();
    tb_check("rb_1234", 32'(a_from_mem), 32'h00001234);

    grant_log.delete();
    r0 = rises;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          xfer(0, 0, 18'(i), 16'h0, 0);
          tick();
        end
      end
      begin
        for (int i = 0; i < 3; i++) begin
          xfer(1, 1, 18'(i + 4), 16'(16'hA000 + i), 0);
          tick();
        end
      end
    join
    wait_idle();
    tb_check("rr_rises", 32'(rises - r0), 6);
    tb_check("rr_len", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      tb_check("rr_seq", 32'(grant_log[i]), 32'(i % 2 == 0));

    ctl_lat = 0;
    xfer(0, 0, 18'h00055, 16'h0, 0);
    repeat (8) tick();
    wait_idle();
    tb_check("to_data", 32'(a_from_mem), 0);
    ctl_lat = 1;

    r0 = rises;
    xfer(0, 0, 18'h00012, 16'h0, 1);
    wait_idle();
    repeat (3) tick();
    tb_check("nodup_1", 32'(rises - r0), 1);
    r0 = rises;
    xfer(0, 0, 18'h00012, 16'h0, 2);
    wait_idle();
    repeat (3) tick();
    tb_check("dup_hold2", 32'(rises - r0), 2);

    ctl_lat = 0;
    a_wren = 0; a_address = 18'h00012; a_req = 1;
    k = 0;
    while (!(pv && pc >= 3) && k < 30) begin
      tick();
      k++;
    end
    tb_check("rst_wait", 32'(pv), 1);
    #1 rst = 1;
    #1 chk_zero();
    a_req = 0;
    repeat (2) tick();
    rst = 0;
    ctl_lat = 1;
    tick();
    xfer(0, 0, 18'h3FFFF, 16'h0, 0);
    wait_idle();
    tb_check("post_rst", 32'(a_from_mem), 32'h00001234);

    ctl_lat = -1;
    fork
      client(0, 25);
      client(1, 25);
    join
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-client arbiter that shares the single SRAM controller port (18-bit address, 16-bit data) between the host programming path (client A) and the on-board verify/checksum engine (client B).
- Accepts level-held requests from each client and grants them round-robin.
- For each granted request it issues one single-cycle request pulse to the SRAM controller, waits for the controller's ready pulse, then returns read data and a one-cycle ready to the owning client.
- A watchdog aborts transactions the controller never completes.

Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles spent in WAIT before abort; legal range 4..255.
- RR_INIT, 0: client treated as last-granted after reset; 0 means A is last-granted, so B wins the first tie.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- a_req  in  1  client A request; held high with stable address/data/wren until a_ready
- a_wren  in  1  client A write enable (1 = write, 0 = read)
- a_address  in  18  client A word address
- a_to_mem  in  16  client A write data
- a_from_mem  out  16  client A read data, valid while a_ready = 1
- a_ready  out  1  client A one-cycle completion pulse
- a_err  out  1  client A timeout flag, valid while a_ready = 1
- b_req, b_wren, b_address, b_to_mem, b_from_mem, b_ready, b_err: same as the client A ports, for client B
- mem_address  out  18  to SRAM controller port address
- mem_to_mem  out  16  to SRAM controller write data
- mem_wren  out  1  to SRAM controller write enable
- mem_req  out  1  to SRAM controller request (controller is rising-edge sensitive)
- mem_from_mem  in  16  from SRAM controller read data
- mem_ready  in  1  from SRAM controller one-cycle completion pulse
- grant_b  out  1  current/last owner (0 = A, 1 = B); debug

Behaviour:
- Reset (async): state IDLE; all outputs 0; last-granted = RR_INIT; watchdog counter 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Sample a_req and b_req.
  - Only one requesting: grant it.
  - Both requesting: grant the client not granted last.
  - On grant, register mem_address, mem_to_mem and mem_wren from the winner, set grant_b, set mem_req = 1, go to ISSUE.
  - No request: stay in IDLE, mem_req = 0.
- ISSUE (exactly 1 cycle):
  - mem_req = 1 and mem bus stable for this cycle.
  - Next edge: mem_req <= 0, counter <= 0, go to WAIT.
  - mem_req therefore rises once per transaction and is low for at least 2 cycles between transactions.
- WAIT:
  - Counter increments each cycle.
  - mem_ready = 1: capture mem_from_mem into the owner's from_mem, err = 0, go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without mem_ready: owner from_mem = 16'h0000, err = 1, go to DONE.
  - Address, data and wren outputs are held unchanged throughout WAIT.
- DONE (exactly 1 cycle):
  - Owner's ready = 1; the other client's ready stays 0.
  - last-granted <= owner.
  - Requests are not sampled in DONE; next state IDLE.
  - The client must drop req at the edge where it registers ready. Its req is then low in the following IDLE cycle, so no duplicate transaction is issued.
  - ready and err clear at the next edge; from_mem holds until the next completion for that client.
- Latency, uncontended, with the SRAM controller at 1-cycle access:
  - req sampled in IDLE at edge 0.
  - mem_req high cycle 0–1.
  - Controller mem_ready high cycle 2–3.
  - Client ready high cycle 3–4.
  - Back-to-back throughput: one transaction per 5 cycles.
- Arbitration:
  - Requests are not pre-empted; an owner keeps the port until DONE.
  - Requests arriving during ISSUE/WAIT/DONE wait in IDLE.
  - Fairness: with both clients continuously requesting, grants alternate A,B,A,B (or B,A… per RR_INIT).
- Stray mem_ready (outside WAIT, e.g. a late response after timeout) is ignored; no client ready is generated.
- A client dropping req before its ready is a protocol violation. The in-flight transaction still completes and pulses ready.
- Reset mid-transaction: all outputs return to 0 immediately; mem_req deasserts. The SRAM controller shares rst and also resets.

Test Plan:
- A read only: preload SRAM 0x00012 = 16'hBEEF; a_req=1, a_wren=0, a_address=18'h00012 → mem_req single pulse with mem_address=18'h00012; a_ready=1 and a_from_mem=16'hBEEF exactly 3 cycles after grant edge; a_err=0; b_ready never asserts.
- B write then A read-back: B writes 16'h1234 to 18'h3FFFF, then A reads 18'h3FFFF → b_ready, then a_ready with a_from_mem=16'h1234.
- Simultaneous requests, RR_INIT=0:
  - a_req and b_req rise in the same cycle → B granted first, then A.
  - Held continuous for 6 transactions → grant_b sequence 1,0,1,0,1,0.
  - Exactly one ready per transaction; mem_req rises 6 times.
- Timeout: replace the controller with a model that never pulses mem_ready; TIMEOUT_CYCLES=8 → a_ready=1, a_err=1, a_from_mem=16'h0000 after 8 WAIT cycles. A mem_ready injected 2 cycles later produces no ready on either client.
- No duplicate issue: client drops req on the edge it sees ready → exactly one mem_req pulse per request. Client holds req 1 extra cycle (violation check) → second transaction issued only after the DONE → IDLE transition.
- Async reset asserted during WAIT → all outputs 0 without a clock edge. After release, a new a_req completes normally with correct data.
